fetch_predict: RTL

Parametrised instruction-fetch stage for the pipelined CPU core. It owns the program counter, drives instruction memory and registers the IF/ID fetch packet. A direct-mapped branch target buffer (BTB) with 2-bit saturating counters predicts branches, so taken branches no longer have to wait for MEM-stage resolution to redirect. Resolution from the EX/MEM stage corrects mispredictions with a one-cycle flush.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/btb_store.sv | 66 ++++++
 rtl/fetch_predict.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: branch-counter encodings,
// the default sequential PC step and the saturating counter update rule.
package cpu_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bc_state_e;

    localparam int DEFAULT_PC_STEP = 4;

    function automatic bc_state_e bc_update(input bc_state_e cur, input logic taken);
        bc_state_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = bc_state_e'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = bc_state_e'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_store.sv
// Direct-mapped BTB storage: combinational lookup port plus a synchronous
// update port that applies the allocate / train / invalidate policy.
module btb_store
    import cpu_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int TAG_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [PC_W-1:0]  rd_target_o,
    output bc_state_e        rd_cnt_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic [TAG_W-1:0] upd_tag_i,
    input  logic             upd_is_branch_i,
    input  logic             upd_taken_i,
    input  logic             upd_pred_taken_i,
    input  logic [PC_W-1:0]  upd_target_i
);

    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [PC_W-1:0]  target_q [DEPTH];
    bc_state_e        cnt_q    [DEPTH];

    logic upd_hit;

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_cnt_o    = cnt_q[rd_idx_i];

    assign upd_hit = valid_q[upd_idx_i] && (tag_q[upd_idx_i] == upd_tag_i);

    // Tags and targets are only meaningful under a valid bit, so only
    // valid and counter state is cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= SNT;
            end
        end else if (upd_en_i) begin
            if (upd_is_branch_i) begin
                if (upd_hit) begin
                    cnt_q[upd_idx_i] <= bc_update(cnt_q[upd_idx_i], upd_taken_i);
                    if (upd_taken_i) target_q[upd_idx_i] <= upd_target_i;
                end else if (upd_taken_i) begin
                    valid_q[upd_idx_i]  <= 1'b1;
                    tag_q[upd_idx_i]    <= upd_tag_i;
                    target_q[upd_idx_i] <= upd_target_i;
                    cnt_q[upd_idx_i]    <= WT;
                end
            end else if (upd_pred_taken_i && upd_hit) begin
                valid_q[upd_idx_i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_predict.sv
// Instruction-fetch stage: PC register, BTB-based next-PC prediction,
// misprediction redirect/flush, IF/ID packet register and perf counters.
module fetch_predict
    import cpu_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter int              INSTR_W   = 16,
    parameter int              BTB_DEPTH = 16,
    parameter int              PC_STEP   = DEFAULT_PC_STEP,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               halt,
    output logic [PC_W-1:0]    im_addr,
    input  logic [INSTR_W-1:0] im_instr,
    output logic               if_valid,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               if_pred_taken,
    output logic [PC_W-1:0]    if_pred_target,
    input  logic               res_valid,
    input  logic [PC_W-1:0]    res_pc,
    input  logic [PC_W-1:0]    res_target,
    input  logic               res_is_branch,
    input  logic               res_taken,
    input  logic               res_pred_taken,
    input  logic [PC_W-1:0]    res_pred_target,
    output logic               flush,
    output logic [CNT_W-1:0]   br_cnt,
    output logic [CNT_W-1:0]   mp_cnt
);

    localparam int OFF   = $clog2(PC_STEP);
    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_W - IDX - OFF;
    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic               if_valid_q, if_valid_d;
    logic [PC_W-1:0]    if_pc_q, if_pc_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic               if_pred_taken_q, if_pred_taken_d;
    logic [PC_W-1:0]    if_pred_target_q, if_pred_target_d;
    logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]   mp_cnt_q, mp_cnt_d;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [PC_W-1:0]  rd_target;
    bc_state_e        rd_cnt;

    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] redirect_pc;
    logic            mispredict;

    btb_store #(
        .PC_W  (PC_W),
        .DEPTH (BTB_DEPTH),
        .IDX_W (IDX),
        .TAG_W (TAG_W)
    ) u_btb (
        .clk              (clk),
        .rst              (rst),
        .rd_idx_i         (pc_q[IDX+OFF-1:OFF]),
        .rd_valid_o       (rd_valid),
        .rd_tag_o         (rd_tag),
        .rd_target_o      (rd_target),
        .rd_cnt_o         (rd_cnt),
        .upd_en_i         (res_valid),
        .upd_idx_i        (res_pc[IDX+OFF-1:OFF]),
        .upd_tag_i        (res_pc[PC_W-1:IDX+OFF]),
        .upd_is_branch_i  (res_is_branch),
        .upd_taken_i      (res_taken),
        .upd_pred_taken_i (res_pred_taken),
        .upd_target_i     (res_target)
    );

    assign pred_taken  = rd_valid && (rd_tag == pc_q[PC_W-1:IDX+OFF])
                         && (rd_cnt == WT || rd_cnt == ST);
    assign pred_target = pred_taken ? rd_target : '0;
    assign next_pc     = pred_taken ? rd_target : pc_q + STEP;

    // A predicted-taken non-branch means the BTB entry aliased onto it.
    assign mispredict = res_valid && (
                            (res_is_branch && (res_taken != res_pred_taken)) ||
                            (res_is_branch && res_taken && (res_target != res_pred_target)) ||
                            (!res_is_branch && res_pred_taken));
    assign flush       = mispredict && !rst;
    assign redirect_pc = res_taken ? res_target : res_pc + STEP;

    always_comb begin
        pc_d             = pc_q;
        if_valid_d       = if_valid_q;
        if_pc_d          = if_pc_q;
        if_instr_d       = if_instr_q;
        if_pred_taken_d  = if_pred_taken_q;
        if_pred_target_d = if_pred_target_q;
        if (flush) begin
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
        end else if (halt) begin
            if_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d             = next_pc;
            if_valid_d       = 1'b1;
            if_pc_d          = pc_q;
            if_instr_d       = im_instr;
            if_pred_taken_d  = pred_taken;
            if_pred_target_d = pred_target;
        end
    end

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (res_valid && res_is_branch && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
        if (flush && (mp_cnt_q != '1))                      mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            if_valid_q       <= 1'b0;
            if_pc_q          <= '0;
            if_instr_q       <= '0;
            if_pred_taken_q  <= 1'b0;
            if_pred_target_q <= '0;
            br_cnt_q         <= '0;
            mp_cnt_q         <= '0;
        end else begin
            pc_q             <= pc_d;
            if_valid_q       <= if_valid_d;
            if_pc_q          <= if_pc_d;
            if_instr_q       <= if_instr_d;
            if_pred_taken_q  <= if_pred_taken_d;
            if_pred_target_q <= if_pred_target_d;
            br_cnt_q         <= br_cnt_d;
            mp_cnt_q         <= mp_cnt_d;
        end
    end

    assign im_addr        = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign if_pred_taken  = if_pred_taken_q;
    assign if_pred_target = if_pred_target_q;
    assign br_cnt         = br_cnt_q;
    assign mp_cnt         = mp_cnt_q;

endmodule
